cla_seq_adder: RTL and testbench
================================

# cla_seq_adder

Multi-cycle wide adder/subtractor controller that time-multiplexes one SLICE-bit carry-lookahead slice across a WIDTH-bit operation. It processes one slice per cycle, least-significant first, and chains the carry between cycles through a carry register. It sits between an operand producer and a result consumer, each with a valid/ready handshake. Area-constrained paths use it in place of a full-width CLA.

## Interface
Parameters:
- WIDTH, 32: operand and result width. Must be an integer multiple of SLICE.
- SLICE, 8: width of the shared CLA slice. NSLICE = WIDTH/SLICE, and NSLICE must be ≥ 2.

Ports:
- clk  in  1  single clock; all state changes on its rising edge
- rst_n  in  1  reset, asynchronous and active-low
- clr  in  1  synchronous abort; returns the block to IDLE
- in_valid  in  1  operands presented
- in_ready  out  1  block can accept operands
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- cin  in  1  carry-in; ignored when op_sub=1
- op_sub  in  1  1 selects A−B, 0 selects A+B+cin
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts the result
- sum  out  WIDTH  result
- cout  out  1  carry-out of bit WIDTH−1; 0 means borrow on subtract
- ovf  out  1  signed two's-complement overflow

## Operation
States: IDLE, RUN, DONE.
- **IDLE**
  - in_ready=1.
  - Accept occurs when in_valid & in_ready at a clock edge.
  - On accept, capture a into the operand register.
  - Capture b, or ~b when op_sub=1.
  - Set the carry register to cin, or to 1 when op_sub=1.
  - Set idx=0 and clear sum.
  - Next state RUN.
- **RUN**
  - Each cycle the slice adds a[idx] and b[idx] (the captured operands) with the carry register.
  - Write the slice result into sum[idx*SLICE +: SLICE].
  - Load the slice carry-out into the carry register, then idx++.
  - On the cycle with idx=NSLICE−1:
    - cout ← slice carry-out.
    - ovf ← slice carry-out XOR carry into the slice MSB.
    - Next state DONE.
- **DONE**
  - out_valid=1.
  - sum, cout and ovf are held stable.
  - On out_valid & out_ready, next state IDLE.
- **in_ready** is 1 only in IDLE. There is no overlap between operations; in_valid is ignored in RUN and DONE.
- **Arithmetic**
  - sum = (a + b + cin) mod 2^WIDTH.
  - Subtract: sum = (a − b) mod 2^WIDTH.
  - Subtract: cout=1 exactly when a ≥ b unsigned.
- **clr**
  - clr=1 at an edge forces IDLE from any state.
  - It clears sum, cout, ovf and idx.
  - It drops out_valid in the next cycle.
  - clr has priority over accept and over the output handshake in the same cycle.
- **rst_n low**, at any time including mid-RUN:
  - Immediately sets state IDLE.
  - Clears sum, cout, ovf, idx and the carry register.
  - The in-flight operation is discarded and never reported.
- **Reset values**: in_ready=1, out_valid=0, sum=0, cout=0, ovf=0.

## Timing
- Accept at edge E0. RUN occupies the cycles after E0 through E(NSLICE).
- out_valid rises after edge E(NSLICE), i.e. NSLICE cycles after accept. This is 4 cycles with the defaults.
- Minimum accept-to-accept interval is NSLICE+2 cycles: NSLICE RUN cycles, 1 DONE cycle with out_ready=1, and 1 IDLE cycle.
- All outputs are registered or decoded directly from the state register. There is no combinational path from any input to any output.
- out_ready held low keeps the block in DONE indefinitely, with outputs unchanged.

## Structure
- **Shared package `cla_pkg`** holds:
  - the state enum (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - the default WIDTH/SLICE constants;
  - a function computing NSLICE and the idx width, $clog2(NSLICE).
- **Sub-module `cla_slice`** (purely combinational), instantiated once:
  - SLICE-bit carry-lookahead built from per-bit generate (A&B) and propagate (A^B) terms.
  - Outputs: s[SLICE], c_out, and c_msb, the carry into the slice MSB, used for ovf.
- The top level holds the FSM, operand registers, carry register, idx counter and result register.

## Test plan
Defaults for all scenarios: WIDTH=32, SLICE=8.
1. a=0xFFFFFFFF, b=0x00000001, cin=0, op_sub=0 -> out_valid exactly 4 cycles after accept; sum=0x00000000, cout=1, ovf=0.
2. a=0x7FFFFFFF, b=0x00000001, cin=0, op_sub=0 -> sum=0x80000000, cout=0, ovf=1.
3. a=5, b=7, op_sub=1, cin=1 (ignored) -> sum=0xFFFFFFFE, cout=0, ovf=0. Then a=7, b=5 -> sum=2, cout=1.
4. Scenario 1 with out_ready held low for 3 cycles in DONE -> sum, cout and ovf stable; in_ready=0; in_valid pulses ignored. Raise out_ready -> in_ready=1 on the following cycle.
5. Accept a=0x12345678, b=0x11111111; assert rst_n=0 on the 2nd RUN cycle -> all outputs 0 immediately, state IDLE. After release, a=0x12345678 + b=0x11111111 yields sum=0x23456789.
6. clr=1 on the 3rd RUN cycle, with in_valid=1 in the same cycle -> IDLE, no accept that cycle, out_valid never asserted for the aborted operation. The next operation completes correctly.

Source files
------------

// File: rtl/cla_pkg.sv
// Shared types and sizing helpers for the sequential CLA adder.
// Imported by the slice and by the controller top.
package cla_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_SLICE = 8;

  // Number of slice passes needed for one operation.
  function automatic int nslice_f(
    input int w,
    input int s
  );
    return w / s;
  endfunction

  // Width of the slice index counter.
  function automatic int idxw_f(
    input int w,
    input int s
  );
    return $clog2(w / s);
  endfunction

endpackage

// File: rtl/cla_slice.sv
// Combinational SLICE-bit carry-lookahead adder.
// Also exposes the carry into the MSB for overflow detection.
module cla_slice
  import cla_pkg::*;
#(
  parameter int SLICE = DEF_SLICE
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             c_in,
  output logic [SLICE-1:0] s,
  output logic             c_out,
  output logic             c_msb
);

  logic [SLICE-1:0] w_g;
  logic [SLICE-1:0] w_p;
  logic [SLICE:0]   w_c;

  assign w_g = a & b;
  assign w_p = a ^ b;

  // Each carry is a flat sum of generate terms gated by the
  // propagates above them, plus c_in through all propagates.
  always_comb begin
    logic v_acc;
    logic v_t;
    v_acc  = 1'b0;
    v_t    = 1'b0;
    w_c    = '0;
    w_c[0] = c_in;
    for (int i = 0; i < SLICE; i++) begin
      v_acc = c_in;
      for (int j = 0; j <= i; j++) begin
        v_acc = v_acc & w_p[j];
      end
      for (int k = 0; k <= i; k++) begin
        v_t = w_g[k];
        for (int j = k + 1; j <= i; j++) begin
          v_t = v_t & w_p[j];
        end
        v_acc = v_acc | v_t;
      end
      w_c[i+1] = v_acc;
    end
  end

  assign s     = w_p ^ w_c[SLICE-1:0];
  assign c_out = w_c[SLICE];
  assign c_msb = w_c[SLICE-1];

endmodule

// File: rtl/cla_seq_adder.sv
// Multi-cycle WIDTH-bit add/sub reusing one CLA slice,
// least-significant slice first, carry chained in a register.
module cla_seq_adder
  import cla_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SLICE = DEF_SLICE
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             op_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NSLICE = nslice_f(WIDTH, SLICE);
  localparam int IDXW   = idxw_f(WIDTH, SLICE);
  localparam logic [IDXW-1:0] LAST = IDXW'(NSLICE - 1);

  state_t r_state;
  state_t w_next;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic [WIDTH-1:0] w_sum_nx;
  logic             r_carry;
  logic             r_cout;
  logic             r_ovf;
  logic [IDXW-1:0]  r_idx;

  logic [SLICE-1:0] w_a_sl;
  logic [SLICE-1:0] w_b_sl;
  logic [SLICE-1:0] w_s;
  logic             w_c_out;
  logic             w_c_msb;
  logic             w_accept;
  logic             w_last;

  assign w_last = (r_idx == LAST);

  // Next-state logic; clr overrides accept and release.
  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (in_valid) begin
          w_accept = 1'b1;
          w_next   = RUN;
        end
      end
      RUN: begin
        if (w_last) begin
          w_next = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
    if (clr) begin
      w_next   = IDLE;
      w_accept = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Select the current operand slices.
  always_comb begin
    w_a_sl = '0;
    w_b_sl = '0;
    for (int k = 0; k < NSLICE; k++) begin
      if (r_idx == IDXW'(k)) begin
        w_a_sl = r_a[k*SLICE +: SLICE];
        w_b_sl = r_b[k*SLICE +: SLICE];
      end
    end
  end

  // Merge the slice result into the running sum.
  always_comb begin
    w_sum_nx = r_sum;
    for (int k = 0; k < NSLICE; k++) begin
      if (r_idx == IDXW'(k)) begin
        w_sum_nx[k*SLICE +: SLICE] = w_s;
      end
    end
  end

  cla_slice #(
    .SLICE (SLICE)
  ) u_slice (
    .a     (w_a_sl),
    .b     (w_b_sl),
    .c_in  (r_carry),
    .s     (w_s),
    .c_out (w_c_out),
    .c_msb (w_c_msb)
  );

  // Operand capture, per-slice accumulation and flag update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_idx   <= '0;
    end else if (clr) begin
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_idx   <= '0;
    end else if (w_accept) begin
      r_a     <= a;
      r_b     <= op_sub ? ~b : b;
      r_carry <= op_sub | cin;
      r_sum   <= '0;
      r_idx   <= '0;
    end else if (r_state == RUN) begin
      r_sum   <= w_sum_nx;
      r_carry <= w_c_out;
      r_idx   <= r_idx + IDXW'(1);
      if (w_last) begin
        r_cout <= w_c_out;
        r_ovf  <= w_c_out ^ w_c_msb;
      end
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_cla_seq_adder.sv
// Directed bench for cla_seq_adder (WIDTH=32, SLICE=8).
// Expected values are hand-computed constants.
module tb_cla_seq_adder;

  logic        clk       = 1'b0;
  logic        rst_n     = 1'b0;
  logic        clr       = 1'b0;
  logic        in_valid  = 1'b0;
  logic        in_ready;
  logic [31:0] a         = '0;
  logic [31:0] b         = '0;
  logic        cin       = 1'b0;
  logic        op_sub    = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] sum;
  logic        cout;
  logic        ovf;

  int n_tot = 0;
  int n_bad = 0;

  cla_seq_adder #(
    .WIDTH (32),
    .SLICE (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .op_sub    (op_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(
    input logic [31:0] xa,
    input logic [31:0] xb,
    input logic        xc,
    input logic        xs
  );
    a        = xa;
    b        = xb;
    cin      = xc;
    op_sub   = xs;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int cnt = 0;
    while (!out_valid && cnt < 20) begin
      tick();
      cnt++;
    end
    chk({tag, ".lat"}, cnt, 4);
  endtask

  task automatic check_res(
    input string       tag,
    input logic [31:0] es,
    input logic        ec,
    input logic        eo
  );
    chk({tag, ".sum"}, sum, es);
    chk({tag, ".cout"}, {31'd0, cout}, {31'd0, ec});
    chk({tag, ".ovf"}, {31'd0, ovf}, {31'd0, eo});
  endtask

  task automatic full_op(
    input string       tag,
    input logic [31:0] xa,
    input logic [31:0] xb,
    input logic        xc,
    input logic        xs,
    input logic [31:0] es,
    input logic        ec,
    input logic        eo
  );
    accept(xa, xb, xc, xs);
    wait_done(tag);
    check_res(tag, es, ec, eo);
    chk({tag, ".rdy_done"}, {31'd0, in_ready}, 32'd0);
    tick();
    chk({tag, ".rdy_idle"}, {31'd0, in_ready}, 32'd1);
    chk({tag, ".vld_idle"}, {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen;
    #2;
    chk("rst.in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst.out_valid", {31'd0, out_valid}, 32'd0);
    check_res("rst", 32'h0, 1'b0, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();

    full_op("t1", 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0,
            32'h0, 1'b1, 1'b0);
    full_op("t2", 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0,
            32'h8000_0000, 1'b0, 1'b1);
    full_op("t3a", 32'd5, 32'd7, 1'b1, 1'b1,
            32'hFFFF_FFFE, 1'b0, 1'b0);
    full_op("t3b", 32'd7, 32'd5, 1'b0, 1'b1,
            32'd2, 1'b1, 1'b0);
    full_op("tcin", 32'h0000_00FF, 32'h0, 1'b1, 1'b0,
            32'h0000_0100, 1'b0, 1'b0);
    full_op("tsub_ovf", 32'h8000_0000, 32'h1, 1'b0, 1'b1,
            32'h7FFF_FFFF, 1'b1, 1'b1);

    // Stall in DONE; in_valid pulses must be ignored.
    out_ready = 1'b0;
    accept(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0);
    wait_done("t4");
    for (int i = 0; i < 3; i++) begin
      a        = 32'h5555_5555;
      b        = 32'h3333_3333;
      in_valid = 1'b1;
      tick();
      check_res("t4.hold", 32'h0, 1'b1, 1'b0);
      chk("t4.rdy", {31'd0, in_ready}, 32'd0);
      chk("t4.vld", {31'd0, out_valid}, 32'd1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("t4.rdy_after", {31'd0, in_ready}, 32'd1);
    chk("t4.vld_after", {31'd0, out_valid}, 32'd0);

    // Async reset during the second RUN cycle.
    accept(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0);
    tick();
    rst_n = 1'b0;
    #1;
    chk("t5.rdy", {31'd0, in_ready}, 32'd1);
    chk("t5.vld", {31'd0, out_valid}, 32'd0);
    check_res("t5.rst", 32'h0, 1'b0, 1'b0);
    tick();
    rst_n = 1'b1;
    seen  = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      seen = seen | out_valid | ~in_ready;
    end
    chk("t5.discard", {31'd0, seen}, 32'd0);
    full_op("t5.op", 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0,
            32'h2345_6789, 1'b0, 1'b0);

    // clr on the third RUN cycle beats a concurrent in_valid.
    accept(32'h0F0F_0F0F, 32'h0101_0101, 1'b0, 1'b0);
    tick();
    tick();
    clr      = 1'b1;
    in_valid = 1'b1;
    a        = 32'hAAAA_AAAA;
    b        = 32'h1;
    tick();
    clr      = 1'b0;
    in_valid = 1'b0;
    chk("t6.rdy", {31'd0, in_ready}, 32'd1);
    chk("t6.vld", {31'd0, out_valid}, 32'd0);
    chk("t6.sum", sum, 32'h0);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      seen = seen | out_valid | ~in_ready;
    end
    chk("t6.discard", {31'd0, seen}, 32'd0);
    full_op("t6.op", 32'h0F0F_0F0F, 32'h0101_0101, 1'b0, 1'b0,
            32'h1010_1010, 1'b0, 1'b0);

    // clr in DONE wins over the output handshake.
    out_ready = 1'b0;
    accept(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0);
    wait_done("t7");
    check_res("t7.pre", 32'h8000_0000, 1'b0, 1'b1);
    clr       = 1'b1;
    out_ready = 1'b1;
    tick();
    clr = 1'b0;
    chk("t7.vld", {31'd0, out_valid}, 32'd0);
    chk("t7.rdy", {31'd0, in_ready}, 32'd1);
    check_res("t7.clr", 32'h0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
